splash_render: RTL and testbench
================================

SPLASH_RENDER -- requirements
Module: splash_render

Interface
REQ-001 Parameter SCR_W, default 160, screen width in pixels.
REQ-002 Parameter SCR_H, default 120, screen height in pixels.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset: synchronous and active-low.
REQ-005 showTitle  input  1  level request to paint the title screen.
REQ-006 showGameOver  input  1  level request to paint the game-over screen.
REQ-007 x  output  8  pixel column to the VGA adapter, registered.
REQ-008 y  output  7  pixel row to the VGA adapter, registered.
REQ-009 colour  output  3  pixel colour {R,G,B}, registered.
REQ-010 plot  output  1  write strobe; x/y/colour valid when high.
REQ-011 busy  output  1  high while a screen sweep is in progress.
REQ-012 done  output  1  one-cycle pulse on sweep completion.

Function
REQ-013 The block SHALL implement states IDLE, DRAW and HOLD.
REQ-014 In IDLE, a high showTitle SHALL latch sel=TITLE and enter DRAW; otherwise a high showGameOver SHALL latch sel=GAMEOVER and enter DRAW.
REQ-015 If both requests are high in the same IDLE cycle, TITLE SHALL win.
REQ-016 In DRAW the block SHALL emit exactly one pixel per cycle with plot=1: x runs 0..SCR_W-1 (inner loop), y runs 0..SCR_H-1 (outer loop).
REQ-017 A request sampled in IDLE on edge k SHALL give pixel (0,0) on the cycle after edge k, and pixel (x,y) y*SCR_W+x cycles later. A full sweep is SCR_W*SCR_H cycles (19200 at defaults).
REQ-018 After pixel (SCR_W-1,SCR_H-1), the block SHALL enter HOLD. In that first HOLD cycle it SHALL drive done=1, plot=0 and busy=0.
REQ-019 busy SHALL equal plot. done SHALL be high for exactly one cycle per completed sweep and never on an aborted one.
REQ-020 In HOLD the block SHALL stay put while the latched request is high. If it drops, the block SHALL return to IDLE. If the other request is high while the latched one is low, the block SHALL return to IDLE and restart from REQ-014 on the next cycle.
REQ-021 If the latched request drops during DRAW, the sweep SHALL abort: plot=0 from the next cycle, return to IDLE, no done pulse.
REQ-022 Pixel colour SHALL be selected by priority: border (REQ-028), then banner, then background.
REQ-023 Banner: rows SCR_H/2-8 .. SCR_H/2+7 (52..67 at defaults); colour 3'b000 for both screens.
REQ-024 Background colour SHALL be 3'b010 for TITLE and 3'b100 for GAMEOVER.
REQ-025 When plot=0, x, y and colour SHALL hold their last values. Counters SHALL never exceed SCR_W-1 / SCR_H-1.

Reset
REQ-026 When rst=0 at a clock edge, the block SHALL go to IDLE with x=0, y=0, colour=0, plot=0, busy=0, done=0 and sel=TITLE.
REQ-027 Reset asserted mid-DRAW or in HOLD SHALL take effect on that edge, with no done pulse. On release, requests SHALL be sampled from IDLE per REQ-014.

Configuration
REQ-028 Macro SPLASH_BORDER_EN: when defined, pixels with x==0, x==SCR_W-1, y==0 or y==SCR_H-1 SHALL be 3'b111. When undefined, those pixels SHALL take banner/background colour per REQ-023/024 and no border logic SHALL be synthesized.

Verification
REQ-029 Reset, then showTitle=1 held -> pixel (0,0) on cycle 1, exactly 19200 plot cycles, done once at cycle 19201, then plot stays 0.
REQ-030 TITLE sweep with SPLASH_BORDER_EN defined -> (0,0)=3'b111, (5,5)=3'b010, (5,60)=3'b000, (159,119)=3'b111. Without the macro -> (0,0)=3'b010.
REQ-031 showGameOver=1 -> (80,30)=3'b100 and (80,52)=3'b000. showTitle and showGameOver high together in IDLE -> TITLE colours.
REQ-032 showTitle dropped at pixel 5000 -> plot=0 on the next cycle, no done, state IDLE. Reassert -> sweep restarts at (0,0).
REQ-033 In HOLD (TITLE): showTitle=0 and showGameOver=1 -> new GAMEOVER sweep starting at (0,0) with 3'b100 background and one done pulse.
REQ-034 rst=0 for one edge at pixel 10000 -> all outputs 0 on the next cycle. With requests low after release -> block stays IDLE.

Source files
------------

// File: rtl/splash_render.sv
// Splash-screen painter: sweeps the whole screen once per request, emitting one pixel per cycle.
// Define SPLASH_BORDER_EN to paint a white one-pixel frame around the screen.
module splash_render #(
  parameter int SCR_W = 160,
  parameter int SCR_H = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       showTitle,
  input  logic       showGameOver,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0] X_MAX  = 8'(SCR_W - 1);
  localparam logic [6:0] Y_MAX  = 7'(SCR_H - 1);
  localparam logic [6:0] BAN_LO = 7'(SCR_H / 2 - 8);
  localparam logic [6:0] BAN_HI = 7'(SCR_H / 2 + 7);

  typedef enum logic [1:0] {IDLE, DRAW, HOLD} state_t;
  typedef enum logic {SEL_TITLE, SEL_GAMEOVER} sel_t;

  state_t     r_state, w_state_nxt;
  sel_t       r_sel, w_sel_nxt;
  logic [7:0] r_x, w_x_nxt;
  logic [6:0] r_y, w_y_nxt;
  logic [2:0] r_colour, w_pix_colour;
  logic       r_plot, w_plot_nxt;
  logic       r_done, w_done_nxt;
  logic       w_req;

  // The request that started the current sweep; dropping it aborts or releases HOLD.
  assign w_req = (r_sel == SEL_TITLE) ? showTitle : showGameOver;

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_plot_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (showTitle) begin
          w_sel_nxt   = SEL_TITLE;
          w_state_nxt = DRAW;
          w_x_nxt     = '0;
          w_y_nxt     = '0;
          w_plot_nxt  = 1'b1;
        end else if (showGameOver) begin
          w_sel_nxt   = SEL_GAMEOVER;
          w_state_nxt = DRAW;
          w_x_nxt     = '0;
          w_y_nxt     = '0;
          w_plot_nxt  = 1'b1;
        end
      end
      DRAW: begin
        if (!w_req) begin
          w_state_nxt = IDLE;
        end else if (r_x == X_MAX && r_y == Y_MAX) begin
          w_state_nxt = HOLD;
          w_done_nxt  = 1'b1;
        end else begin
          w_plot_nxt = 1'b1;
          if (r_x == X_MAX) begin
            w_x_nxt = '0;
            w_y_nxt = r_y + 7'd1;
          end else begin
            w_x_nxt = r_x + 8'd1;
          end
        end
      end
      HOLD: begin
        if (!w_req) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Colour of the pixel about to be emitted, evaluated on next-cycle coordinates.
  always_comb begin
    w_pix_colour = (w_sel_nxt == SEL_TITLE) ? 3'b010 : 3'b100;
    if (w_y_nxt >= BAN_LO && w_y_nxt <= BAN_HI) w_pix_colour = 3'b000;
`ifdef SPLASH_BORDER_EN
    if (w_x_nxt == 8'd0 || w_x_nxt == X_MAX || w_y_nxt == 7'd0 || w_y_nxt == Y_MAX)
      w_pix_colour = 3'b111;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_sel    <= SEL_TITLE;
      r_x      <= '0;
      r_y      <= '0;
      r_colour <= '0;
      r_plot   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_plot  <= w_plot_nxt;
      r_done  <= w_done_nxt;
      if (w_plot_nxt) r_colour <= w_pix_colour;
    end
  end

  assign x      = r_x;
  assign y      = r_y;
  assign colour = r_colour;
  assign plot   = r_plot;
  assign busy   = r_plot;
  assign done   = r_done;

endmodule

// File: tb/tb_splash_render.sv
// Directed bench for splash_render: table of pixel colours checked during sweeps,
// plus hand-written abort, HOLD hand-over and mid-sweep reset sequences.
module tb_splash_render;

  localparam int W  = 160;
  localparam int H  = 120;
  localparam int NV = 18;
`ifdef SPLASH_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       showTitle = 1'b0;
  logic       showGameOver = 1'b0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, done;

  int n_checks = 0;
  int n_err    = 0;

  // mode: 0 = TITLE sweep, 1 = GAMEOVER sweep, 2 = both requests raised together
  typedef struct packed {
    logic [1:0] mode;
    logic [7:0] px;
    logic [6:0] py;
    logic [2:0] exp;
  } vec_t;
  vec_t vecs [NV];

  splash_render #(.SCR_W(W), .SCR_H(H)) dut (
    .clk(clk), .rst(rst), .showTitle(showTitle), .showGameOver(showGameOver),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] edge_col(input logic [2:0] inner);
    return BORDER ? 3'b111 : inner;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Follows pixels first..first+n-1 of a sweep, one per cycle, checking table colours.
  task automatic sweep(input int mode, input int first, input int n);
    int bad = 0;
    for (int i = first; i < first + n; i++) begin
      @(negedge clk);
      if (!(plot === 1'b1 && busy === 1'b1 && done === 1'b0 &&
            x === 8'(i % W) && y === 7'(i / W))) bad++;
      for (int k = 0; k < NV; k++)
        if (int'(vecs[k].mode) == mode && int'(vecs[k].py) * W + int'(vecs[k].px) == i)
          check($sformatf("colour m%0d (%0d,%0d)", mode, vecs[k].px, vecs[k].py),
                32'(colour), 32'(vecs[k].exp));
    end
    check($sformatf("sweep_seq m%0d from %0d", mode, first), bad, 0);
  endtask

  initial begin
    int bad;
    vecs[0]  = '{2'd0, 8'd0,   7'd0,   edge_col(3'b010)};
    vecs[1]  = '{2'd0, 8'd5,   7'd5,   3'b010};
    vecs[2]  = '{2'd0, 8'd5,   7'd60,  3'b000};
    vecs[3]  = '{2'd0, 8'd80,  7'd51,  3'b010};
    vecs[4]  = '{2'd0, 8'd80,  7'd52,  3'b000};
    vecs[5]  = '{2'd0, 8'd80,  7'd67,  3'b000};
    vecs[6]  = '{2'd0, 8'd80,  7'd68,  3'b010};
    vecs[7]  = '{2'd0, 8'd159, 7'd119, edge_col(3'b010)};
    vecs[8]  = '{2'd0, 8'd159, 7'd60,  edge_col(3'b000)};
    vecs[9]  = '{2'd1, 8'd0,   7'd0,   edge_col(3'b100)};
    vecs[10] = '{2'd1, 8'd80,  7'd30,  3'b100};
    vecs[11] = '{2'd1, 8'd80,  7'd52,  3'b000};
    vecs[12] = '{2'd1, 8'd10,  7'd67,  3'b000};
    vecs[13] = '{2'd1, 8'd159, 7'd68,  edge_col(3'b100)};
    vecs[14] = '{2'd1, 8'd80,  7'd119, edge_col(3'b100)};
    vecs[15] = '{2'd2, 8'd0,   7'd0,   edge_col(3'b010)};
    vecs[16] = '{2'd2, 8'd5,   7'd5,   3'b010};
    vecs[17] = '{2'd2, 8'd80,  7'd3,   3'b010};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", {x, y, colour, plot, busy, done}, 0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_no_plot", {plot, busy, done}, 0);

    // Full TITLE sweep with request held, then HOLD
    showTitle = 1'b1;
    sweep(0, 0, W * H);
    @(negedge clk);
    check("title_done_pulse", {done, plot, busy}, 3'b100);
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if ({done, plot, busy} !== 3'b000) bad++;
    end
    check("title_hold_quiet", bad, 0);

    // HOLD hand-over to GAMEOVER: back through IDLE, then a new sweep
    showTitle = 1'b0;
    showGameOver = 1'b1;
    @(negedge clk);
    check("hold_exit_idle", {done, plot, busy}, 0);
    sweep(1, 0, W * H);
    @(negedge clk);
    check("go_done_pulse", {done, plot, busy}, 3'b100);
    showGameOver = 1'b0;
    @(negedge clk);
    check("go_release_idle", {done, plot, busy}, 0);

    // Both requests together: TITLE wins; drop both to abort
    showTitle = 1'b1;
    showGameOver = 1'b1;
    sweep(2, 0, 806);
    showTitle = 1'b0;
    showGameOver = 1'b0;
    @(negedge clk);
    check("both_abort", {done, plot, busy}, 0);

    // Abort at pixel 5000: outputs frozen, no done, then restart from (0,0)
    showTitle = 1'b1;
    sweep(0, 0, 5001);
    showTitle = 1'b0;
    @(negedge clk);
    check("abort_no_plot", {done, plot, busy}, 0);
    check("abort_hold_xyc", {x, y, colour}, {8'd40, 7'd31, 3'b010});
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if ({done, plot, busy} !== 3'b000) bad++;
    end
    check("abort_stays_idle", bad, 0);

    // Restart, then reset at pixel 10000
    showTitle = 1'b1;
    sweep(0, 0, 10001);
    rst = 1'b0;
    @(negedge clk);
    check("reset_mid_draw", {x, y, colour, plot, busy, done}, 0);
    rst = 1'b1;
    showTitle = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if ({done, plot, busy} !== 3'b000) bad++;
    end
    check("idle_after_reset", bad, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
